seg7_scan: RTL and testbench

Multiplexed 8-digit hexadecimal 7-segment display driver. It is the consumer side of the keypad entry buffer: it takes the 32-bit accumulated value and scans it out one nibble per digit on a common-anode display. It snapshots the value once per frame so a display never shows a torn word. Optional leading-zero blanking and per-digit decimal points are provided.

---
 rtl/seg7_pkg.sv | 12 +
 rtl/hex7seg.sv | 9 +
 rtl/seg7_scan.sv | 48 ++++
 tb/tb_seg7_scan.sv | 117 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment constants and the active-low gfedcba hex table
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [111:0] HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    return HEX_TABLE[int'(n) * 7 +: 7];
  endfunction
endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational nibble to active-low {g,f,e,d,c,b,a} segment decoder
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex_seg(nibble);
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed hex display scanner (clock, reset active-low sync, value/blank_lz/dp_mask in; an/seg/dp active-low registered out)
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  blank_lz,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp
);
  localparam int W = 4 * N_DIGITS;
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [W-1:0] snap;
  logic [3:0] nib;
  logic [6:0] dec;
  logic wrap, last, blank;
  assign wrap = cnt == CW'(SCAN_DIV - 1);
  assign last = idx == IW'(N_DIGITS - 1);
  assign nib = snap[4 * idx +: 4];
  assign blank = blank_lz && idx != '0 && (snap >> (4 * idx)) == '0;
  hex7seg u_dec (.nibble(nib), .seg(dec));
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt  <= '0;
      idx  <= '0;
      snap <= '0;
      an   <= '1;
      seg  <= SEG_BLANK;
      dp   <= 1'b1;
    end else begin
      cnt  <= wrap ? '0 : cnt + CW'(1);
      idx  <= wrap ? (last ? '0 : idx + IW'(1)) : idx;
      snap <= wrap && last ? value : snap;
      an   <= ~(N_DIGITS'(1) << idx);
      seg  <= blank ? SEG_BLANK : dec;
      dp   <= ~dp_mask[idx];
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: table-driven check of scan order, snapshot, blanking, dp and reset
module tb_seg7_scan;
  logic clock = 1'b0;
  logic reset;
  logic [31:0] value;
  logic blank_lz;
  logic [7:0] dp_mask;
  logic [7:0] an;
  logic [6:0] seg;
  logic dp;
  int total = 0;
  int bad = 0;
  int k = 0;
  typedef struct {
    int k;
    logic [31:0] value;
    logic blz;
    logic [7:0] dpm;
    logic [7:0] an;
    logic [6:0] seg;
    logic dp;
  } vec_t;
  vec_t vt[$];
  always #5 clock = ~clock;
  seg7_scan #(.N_DIGITS(8), .SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .value(value), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp)
  );
  task automatic tick();
    @(posedge clock);
    #1;
    k++;
  endtask
  task automatic check(input string name, input logic [7:0] ea, input logic [6:0] es, input logic ed);
    total++;
    if (an !== ea || seg !== es || dp !== ed) begin
      bad++;
      $display("FAIL %s k=%0d: an=%h seg=%h dp=%b, required an=%h seg=%h dp=%b",
               name, k, an, seg, dp, ea, es, ed);
    end
  endtask
  task automatic add(input int kk, input logic [31:0] v, input logic b, input logic [7:0] m,
                     input logic [7:0] a, input logic [6:0] s, input logic d);
    vec_t e;
    e.k = kk; e.value = v; e.blz = b; e.dpm = m; e.an = a; e.seg = s; e.dp = d;
    vt.push_back(e);
  endtask
  initial begin
    add(14,  32'h1234ABCD, 0, 8'h00, 8'hF7, 7'h40, 1);
    add(34,  32'h1234ABCD, 0, 8'h00, 8'hFE, 7'h21, 1);
    add(36,  32'h1234ABCD, 0, 8'h00, 8'hFE, 7'h21, 1);
    add(37,  32'h1234ABCD, 0, 8'h00, 8'hFD, 7'h46, 1);
    add(38,  32'h1234ABCD, 0, 8'h00, 8'hFD, 7'h46, 1);
    add(42,  32'h1234ABCD, 0, 8'h00, 8'hFB, 7'h03, 1);
    add(46,  32'h1234ABCD, 0, 8'h00, 8'hF7, 7'h08, 1);
    add(50,  32'h1234ABCD, 0, 8'h00, 8'hEF, 7'h19, 1);
    add(54,  32'h1234ABCD, 0, 8'h00, 8'hDF, 7'h30, 1);
    add(58,  32'h1234ABCD, 0, 8'h00, 8'hBF, 7'h24, 1);
    add(62,  32'h1234ABCD, 0, 8'h00, 8'h7F, 7'h79, 1);
    add(66,  32'h1234ABCD, 0, 8'h00, 8'hFE, 7'h21, 1);
    add(78,  32'h00000000, 0, 8'h00, 8'hF7, 7'h08, 1);
    add(82,  32'h00000000, 0, 8'h00, 8'hEF, 7'h19, 1);
    add(86,  32'h00000000, 0, 8'h00, 8'hDF, 7'h30, 1);
    add(90,  32'h00000000, 0, 8'h00, 8'hBF, 7'h24, 1);
    add(94,  32'h00000000, 0, 8'h00, 8'h7F, 7'h79, 1);
    add(98,  32'h00000000, 0, 8'h00, 8'hFE, 7'h40, 1);
    add(110, 32'h00000000, 0, 8'h00, 8'hF7, 7'h40, 1);
    add(126, 32'h0000002A, 0, 8'h00, 8'h7F, 7'h40, 1);
    add(130, 32'h0000002A, 1, 8'h00, 8'hFE, 7'h08, 1);
    add(134, 32'h0000002A, 1, 8'h00, 8'hFD, 7'h24, 1);
    add(138, 32'h0000002A, 1, 8'h00, 8'hFB, 7'h7F, 1);
    add(150, 32'h0000002A, 1, 8'h00, 8'hDF, 7'h7F, 1);
    add(158, 32'h00000000, 1, 8'h00, 8'h7F, 7'h7F, 1);
    add(162, 32'h00000000, 1, 8'h00, 8'hFE, 7'h40, 1);
    add(166, 32'h00000000, 1, 8'h00, 8'hFD, 7'h7F, 1);
    add(170, 32'h00000000, 1, 8'h04, 8'hFB, 7'h7F, 0);
    add(174, 32'h00000000, 1, 8'h04, 8'hF7, 7'h7F, 1);
    add(175, 32'h00000000, 1, 8'h08, 8'hF7, 7'h7F, 0);
    add(176, 32'h00000000, 1, 8'h00, 8'hF7, 7'h7F, 1);
    add(178, 32'h00000000, 1, 8'h00, 8'hEF, 7'h7F, 1);
    add(182, 32'h00000000, 0, 8'h00, 8'hDF, 7'h40, 1);
    reset = 1'b0;
    value = 32'hFFFFFFFF;
    blank_lz = 1'b1;
    dp_mask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", 8'hFF, 7'h7F, 1'b1);
    end
    reset = 1'b1;
    blank_lz = 1'b0;
    dp_mask = 8'h00;
    k = 0;
    tick();
    check("reset_release", 8'hFE, 7'h40, 1'b1);
    foreach (vt[i]) begin
      value = vt[i].value;
      blank_lz = vt[i].blz;
      dp_mask = vt[i].dpm;
      while (k < vt[i].k) tick();
      check($sformatf("vec%0d", i), vt[i].an, vt[i].seg, vt[i].dp);
    end
    while (k < 214) tick();
    check("pre_midreset", 8'hDF, 7'h40, 1'b1);
    reset = 1'b0;
    value = 32'hFFFFFFFF;
    tick();
    check("midscan_reset", 8'hFF, 7'h7F, 1'b1);
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("restart_dwell%0d", i), i <= 4 ? 8'hFE : 8'hFD, 7'h40, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
